imem_arbiter: RTL and testbench
===============================

# imem_arbiter

Shares the single-port synchronous instruction memory between the CPU fetch stage and the program loader (boot/debug write path). It sequences one access per slot, handles the memory read latency, and returns fetched instructions with a valid pulse. Starvation of the loader is bounded. It sits between the IF stage and the instruction memory; the IF stage stalls on it instead of reading the memory combinationally.

## Interface

- `AW`, 8: memory address width. `mem_addr` is the byte address `addr[AW-1:0]`, unmodified, as the instruction memory indexes it.
- `RD_LAT`, 1: memory read latency in cycles, from `mem_en` to valid `mem_rdata`. Legal values are 1..3.
- `STARVE_MAX`, 4: maximum number of consecutive fetch grants while a load is pending, before the loader is forced a slot.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `boot_mode`  in  1  when 1, the loader has absolute priority and `cpu_hold` is asserted.
- `fetch_req`  in  1  fetch request. It is held, with `fetch_addr` stable, until `fetch_valid`.
- `fetch_addr`  in  32  fetch byte address (PC).
- `fetch_valid`  out  1  one-cycle pulse; `fetch_instr` is valid.
- `fetch_instr`  out  32  fetched instruction.
- `fetch_err`  out  1  one-cycle pulse in place of `fetch_valid` when `fetch_addr[1:0]!=0`.
- `load_req`  in  1  write request. It is held, with `load_addr` and `load_data` stable, until `load_ack`.
- `load_addr`  in  32  write byte address.
- `load_data`  in  32  write data.
- `load_ack`  out  1  one-cycle pulse in the cycle the write is issued to memory.
- `cpu_hold`  out  1  1 while `boot_mode` is set or a load write is in progress.
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  memory write enable; only valid with `mem_en`.
- `mem_addr`  out  AW  memory address.
- `mem_wdata`  out  32  memory write data.
- `mem_rdata`  in  32  memory read data.

## Operation

- **FSM states:** IDLE, RD_WAIT, RD_DONE, WR.
- **IDLE, grant decision**, evaluated every cycle:
  - `boot_mode && load_req` → WR.
  - `!boot_mode && fetch_req && (!load_req || starve_cnt<STARVE_MAX)` → issue read.
  - Any other pending `load_req` → WR.
- **Misaligned fetch:** no memory access is made. `fetch_err` pulses the next cycle and the FSM stays in IDLE.
- **Read issue:** drive `mem_en=1`, `mem_we=0`, `mem_addr=fetch_addr[AW-1:0]`, then go to RD_WAIT. A down-counter is loaded with RD_LAT-1.
- **RD_WAIT:** decrements the counter. At 0 → RD_DONE, capturing `mem_rdata` into `fetch_instr`.
- **RD_DONE:** pulses `fetch_valid` → IDLE.
- **WR:** drives `mem_en=1`, `mem_we=1`, `mem_addr`, `mem_wdata`, and `load_ack=1` for one cycle → IDLE.
- **`starve_cnt`** (width clog2(STARVE_MAX+1)):
  - Increments on each fetch grant while `load_req` is high.
  - Clears on each WR.
  - Saturates at STARVE_MAX.
- **boot_mode:** fetch grants are blocked. A pending fetch waits; it is not dropped.
- **Address bits:** addresses above `AW` bits are ignored, so they wrap within the memory.
- **Simultaneous events:**
  - `fetch_req` and `load_req` in the same IDLE cycle resolve by the priority rule above. There is no combinational ack in the same cycle.
  - Deasserting `fetch_req` mid-read is a protocol violation. The read still completes and `fetch_valid` still pulses.
- **Reset**, asynchronous, including mid-read:
  - FSM → IDLE, `starve_cnt`=0.
  - All outputs are 0, including `fetch_instr`=32'h0 and `cpu_hold`=0.
  - Any in-flight read is discarded.

## Timing

- **Fetch:** the grant is cycle T (`mem_en` high). `fetch_valid` pulses at T+RD_LAT+1. With RD_LAT=1, throughput is one fetch per 3 cycles.
- **Load:** `load_ack` coincides with `mem_we` in the WR cycle. The earliest next grant is the following cycle.
- **Misaligned fetch:** `fetch_err` is asserted the cycle after detection.
- **Register rules:**
  - `mem_*` outputs are decoded from the FSM state and the registered grant.
  - `fetch_valid`, `fetch_err` and `load_ack` are registered or state-decoded pulses, exactly one cycle wide.
- **`cpu_hold`:** asserted combinationally from `boot_mode` OR state==WR.

## Structure

- **Shared package `imem_pkg`:**
  - State enum (IDLE/RD_WAIT/RD_DONE/WR).
  - `IMEM_AW`=8.
  - The NOP encoding 32'h00000000, used by the IF stage on stall.
- **Sub-module `imem_lat_cnt`:** the RD_LAT down-counter with load and done signals.
- Everything else stays in one module.

## Test plan

- **Basic fetch:** RD_LAT=1, memory word at address 4 = 32'h8C210001, fetch_req at 4 → `mem_en` in cycle T, `fetch_valid` in T+2 with `fetch_instr`=32'h8C210001.
- **Boot load:** `boot_mode`=1, load 0xDEADBEEF to address 28 → `load_ack` and `mem_we` for exactly one cycle, `cpu_hold`=1 throughout. A subsequent fetch of 28 with `boot_mode`=0 returns 0xDEADBEEF.
- **Starvation bound:** STARVE_MAX=4, `fetch_req` and `load_req` held continuously → exactly 4 fetch grants, then 1 WR, then the fetches resume.
- **Misaligned fetch:** fetch_addr=6 → `fetch_err` pulses, with no `mem_en` and no `fetch_valid`.
- **Latency sweep:** RD_LAT=3 → `fetch_valid` at T+4, with data captured from `mem_rdata` in cycle T+3.
- **Reset mid-read:** `rst_n` low during RD_WAIT → all outputs 0 immediately. After release, the re-requested fetch completes normally with no stale `fetch_valid`.

Source files
------------

// File: rtl/imem_arbiter_pkg.sv
// Shared types and constants for the instruction-memory arbiter slice.
package imem_pkg;

  localparam int IMEM_AW = 8;
  localparam int LAT_W   = 2;
  localparam logic [31:0] IMEM_NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RD_DONE,
    WR
  } imem_state_e;

endpackage

// File: rtl/imem_arbiter_if.sv
// Fetch, loader and memory-side signals of the instruction-memory arbiter.
interface imem_arbiter_if
  import imem_pkg::*;
#(
  parameter int AW = IMEM_AW
);
  logic          boot_mode;
  logic          fetch_req;
  logic [31:0]   fetch_addr;
  logic          fetch_valid;
  logic [31:0]   fetch_instr;
  logic          fetch_err;
  logic          load_req;
  logic [31:0]   load_addr;
  logic [31:0]   load_data;
  logic          load_ack;
  logic          cpu_hold;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  // master: the fetch stage, loader and memory; slave: the arbiter
  modport master (
    output boot_mode, fetch_req, fetch_addr, load_req, load_addr, load_data, mem_rdata,
    input  fetch_valid, fetch_instr, fetch_err, load_ack, cpu_hold,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  boot_mode, fetch_req, fetch_addr, load_req, load_addr, load_data, mem_rdata,
    output fetch_valid, fetch_instr, fetch_err, load_ack, cpu_hold,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_arbiter_lat_cnt.sv
// Read-latency down-counter: loaded at read issue, done when it reaches zero.
module imem_lat_cnt
  import imem_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic [LAT_W-1:0] ld_val,
  output logic             done
);
  logic [LAT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (ld) begin
      cnt_q <= ld_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - LAT_W'(1);
    end
  end

  assign done = (cnt_q == '0);
endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates the single-port instruction memory between CPU fetch and the program loader.
//   state   | meaning
//   IDLE    | grant decision; a read is issued (mem_en) directly from this state
//   RD_WAIT | waiting out the memory read latency, captures mem_rdata at the end
//   RD_DONE | fetch_valid pulse
//   WR      | loader write issued to memory, load_ack pulse
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int AW         = IMEM_AW,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  imem_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_MAX + 1);

  imem_state_e   state_q, state_d;
  logic [SW-1:0] starve_q;
  logic [31:0]   instr_q;
  logic          err_q;
  logic          fetch_win, misaligned, rd_issue, lat_done;
  logic          unused_hi;

  assign unused_hi = ^{bus.fetch_addr[31:AW], bus.load_addr[31:AW]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // err_q blocks a re-grant while the requester is still reacting to fetch_err
    fetch_win  = !bus.boot_mode && bus.fetch_req && !err_q &&
                 (!bus.load_req || (starve_q < SW'(STARVE_MAX)));
    misaligned = (bus.fetch_addr[1:0] != 2'b00);
    rd_issue   = rst_n && (state_q == IDLE) && fetch_win && !misaligned;
    state_d    = state_q;
    case (state_q)
      IDLE: begin
        if (fetch_win) begin
          if (!misaligned) state_d = RD_WAIT;
        end else if (bus.load_req) begin
          state_d = WR;
        end
      end
      RD_WAIT: if (lat_done) state_d = RD_DONE;
      RD_DONE: state_d = IDLE;
      WR:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_en    = rd_issue || (state_q == WR);
    bus.mem_we    = (state_q == WR);
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (state_q == WR) begin
      bus.mem_addr  = bus.load_addr[AW-1:0];
      bus.mem_wdata = bus.load_data;
    end else if (rd_issue) begin
      bus.mem_addr  = bus.fetch_addr[AW-1:0];
    end
  end

  assign bus.fetch_valid = (state_q == RD_DONE);
  assign bus.fetch_instr = instr_q;
  assign bus.fetch_err   = err_q;
  assign bus.load_ack    = (state_q == WR);
  assign bus.cpu_hold    = rst_n && (bus.boot_mode || (state_q == WR));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
      instr_q  <= IMEM_NOP;
      err_q    <= 1'b0;
    end else begin
      err_q <= (state_q == IDLE) && fetch_win && misaligned;
      if ((state_q == RD_WAIT) && lat_done) instr_q <= bus.mem_rdata;
      if (state_q == WR) begin
        starve_q <= '0;
      end else if (rd_issue && bus.load_req && (starve_q < SW'(STARVE_MAX))) begin
        starve_q <= starve_q + SW'(1);
      end
    end
  end

  imem_lat_cnt u_lat (
    .clk    (clk),
    .rst_n  (rst_n),
    .ld     (rd_issue),
    .ld_val (LAT_W'(RD_LAT - 1)),
    .done   (lat_done)
  );
endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: RD_LAT=1 and RD_LAT=3 instances against a shadow-memory model.
module tb_imem_arbiter;
  import imem_pkg::*;
  localparam int AW = IMEM_AW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  imem_arbiter_if #(.AW(AW)) b1 ();
  imem_arbiter_if #(.AW(AW)) b3 ();

  imem_arbiter #(.AW(AW), .RD_LAT(1), .STARVE_MAX(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  imem_arbiter #(.AW(AW), .RD_LAT(3), .STARVE_MAX(4)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  // Memory models: junk on mem_rdata except in the cycle the read data is due
  logic [31:0] mem1 [64];
  logic [31:0] mem3 [64];
  logic [31:0] rd1;
  logic [31:0] pipe3 [3];
  always @(posedge clk) begin
    if (b1.mem_en && b1.mem_we) mem1[b1.mem_addr[AW-1:2]] <= b1.mem_wdata;
    rd1 <= (b1.mem_en && !b1.mem_we) ? mem1[b1.mem_addr[AW-1:2]] : $urandom;
    if (b3.mem_en && b3.mem_we) mem3[b3.mem_addr[AW-1:2]] <= b3.mem_wdata;
    pipe3[0] <= (b3.mem_en && !b3.mem_we) ? mem3[b3.mem_addr[AW-1:2]] : $urandom;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign b1.mem_rdata = rd1;
  assign b3.mem_rdata = pipe3[2];

  // Reference: what the loader has written, word-indexed
  logic [31:0] ref1 [64];
  bit          wr1  [64];
  int checks = 0;
  int fails  = 0;

  typedef struct packed {
    logic en, we, valid, err, ack, hold;
    logic [7:0]  addr;
    logic [31:0] wdata, instr;
  } snap_t;

  function automatic snap_t snap(input bit s);
    snap_t r;
    if (s) r = {b3.mem_en, b3.mem_we, b3.fetch_valid, b3.fetch_err, b3.load_ack, b3.cpu_hold,
                b3.mem_addr, b3.mem_wdata, b3.fetch_instr};
    else   r = {b1.mem_en, b1.mem_we, b1.fetch_valid, b1.fetch_err, b1.load_ack, b1.cpu_hold,
                b1.mem_addr, b1.mem_wdata, b1.fetch_instr};
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fetch(input bit s, input logic req, input logic [31:0] a);
    if (s) begin b3.fetch_req = req; b3.fetch_addr = a; end
    else   begin b1.fetch_req = req; b1.fetch_addr = a; end
  endtask

  task automatic set_load(input bit s, input logic req, input logic [31:0] a, input logic [31:0] d);
    if (s) begin b3.load_req = req; b3.load_addr = a; b3.load_data = d; end
    else   begin b1.load_req = req; b1.load_addr = a; b1.load_data = d; end
  endtask

  task automatic set_boot(input bit s, input logic v);
    if (s) b3.boot_mode = v;
    else   b1.boot_mode = v;
  endtask

  // Holds a fetch until fetch_valid/fetch_err; lat counts cycles from the first read grant
  task automatic do_fetch(input bit s, input logic [31:0] a, output logic [31:0] instr,
                          output int lat, output logic err, output int n_rd,
                          output logic [7:0] gaddr, output bit done);
    snap_t v;
    int g;
    g = -1; lat = -1; err = 1'b0; n_rd = 0; instr = '0; gaddr = '0; done = 1'b0;
    set_fetch(s, 1'b1, a);
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clk);
      v = snap(s);
      if (v.en && !v.we) begin
        n_rd++;
        if (g < 0) begin g = t; gaddr = v.addr; end
      end
      if (v.valid || v.err) begin
        done = 1'b1; instr = v.instr; err = v.err; lat = (g < 0) ? -1 : t - g;
      end
      tick();
    end
    set_fetch(s, 1'b0, a);
  endtask

  // Holds a load until load_ack, then samples one extra cycle after releasing it
  task automatic do_load(input bit s, input logic [31:0] a, input logic [31:0] d,
                         output int n_ack, output int n_we, output int n_rd, output int n_nohold,
                         output logic [7:0] waddr, output logic [31:0] wdata, output bit done);
    snap_t v;
    bit stop;
    n_ack = 0; n_we = 0; n_rd = 0; n_nohold = 0; waddr = '0; wdata = '0; done = 1'b0; stop = 1'b0;
    set_load(s, 1'b1, a, d);
    for (int t = 0; t < 40 && !stop; t++) begin
      @(negedge clk);
      v = snap(s);
      if (v.ack) n_ack++;
      if (v.en && v.we) begin n_we++; waddr = v.addr; wdata = v.wdata; end
      if (v.en && !v.we) n_rd++;
      if (!v.hold) n_nohold++;
      if (done) stop = 1'b1;
      if (v.ack) done = 1'b1;
      tick();
      if (done) set_load(s, 1'b0, a, d);
    end
    set_load(s, 1'b0, a, d);
  endtask

  task automatic test_reset();
    snap_t v;
    rst_n = 1'b0;
    set_boot(0, 1'b1); set_fetch(0, 1'b1, 32'h4); set_load(0, 1'b1, 32'h8, 32'h1234_5678);
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      v = snap(s[0]);
      checks++;
      if (v !== '0) begin
        fails++; $display("FAIL reset_outputs dut%0d got %h want 0", s, v);
      end
    end
    set_boot(0, 1'b0); set_fetch(0, 1'b0, '0); set_load(0, 1'b0, '0, '0);
    tick();
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      v = snap(0);
      checks++;
      if (v !== '0) begin fails++; $display("FAIL reset_release_idle got %h want 0", v); end
      tick();
    end
  endtask

  task automatic test_basic_fetch();
    logic [31:0] instr, wd; logic [7:0] wa, ga; logic err;
    int lat, nr, na, nw, nh; bit done;
    do_load(0, 32'h4, 32'h8C21_0001, na, nw, nr, nh, wa, wd, done);
    checks++;
    if ({done, na, nw, wa, wd} !== {1'b1, 32'd1, 32'd1, 8'd4, 32'h8C21_0001}) begin
      fails++; $display("FAIL basic_load done=%0d acks=%0d we=%0d addr=%h data=%h want 1/1/1/04/8c210001",
                        done, na, nw, wa, wd);
    end
    ref1[1] = 32'h8C21_0001; wr1[1] = 1'b1;
    do_fetch(0, 32'h4, instr, lat, err, nr, ga, done);
    checks++;
    if ({done, err, lat, nr, ga, instr} !== {1'b1, 1'b0, 32'd2, 32'd1, 8'd4, 32'h8C21_0001}) begin
      fails++; $display("FAIL basic_fetch done=%0d err=%0d lat=%0d reads=%0d addr=%h instr=%h want 1/0/2/1/04/8c210001",
                        done, err, lat, nr, ga, instr);
    end
  endtask

  task automatic test_boot_load();
    snap_t v; logic [31:0] instr, wd; logic [7:0] wa, ga; logic err;
    int lat, nr, na, nw, nh; bit done;
    set_boot(0, 1'b1);
    set_fetch(0, 1'b1, 32'd28);
    do_load(0, 32'd28, 32'hDEAD_BEEF, na, nw, nr, nh, wa, wd, done);
    checks++;
    if ({done, na, nw, nr, nh, wa, wd} !== {1'b1, 32'd1, 32'd1, 32'd0, 32'd0, 8'd28, 32'hDEAD_BEEF}) begin
      fails++; $display("FAIL boot_load done=%0d acks=%0d we=%0d reads=%0d hold_low=%0d addr=%h data=%h want 1/1/1/0/0/1c/deadbeef",
                        done, na, nw, nr, nh, wa, wd);
    end
    ref1[7] = 32'hDEAD_BEEF; wr1[7] = 1'b1;
    repeat (4) begin
      @(negedge clk);
      v = snap(0);
      checks++;
      if (v.en !== 1'b0 || v.hold !== 1'b1) begin
        fails++; $display("FAIL boot_fetch_blocked mem_en=%b cpu_hold=%b want 0/1", v.en, v.hold);
      end
      tick();
    end
    set_boot(0, 1'b0);
    do_fetch(0, 32'd28, instr, lat, err, nr, ga, done);
    checks++;
    if ({done, err, lat, instr} !== {1'b1, 1'b0, 32'd2, 32'hDEAD_BEEF}) begin
      fails++; $display("FAIL boot_refetch done=%0d err=%0d lat=%0d instr=%h want 1/0/2/deadbeef",
                        done, err, lat, instr);
    end
  endtask

  task automatic test_misaligned();
    snap_t v; logic [31:0] a, instr; logic [7:0] ga; logic err;
    int lat, nr; bit done;
    for (int i = 0; i < 4; i++) begin
      a = (i == 0) ? 32'd6 : $urandom;
      if (a[1:0] == 2'b00) a[0] = 1'b1;
      do_fetch(0, a, instr, lat, err, nr, ga, done);
      checks++;
      if ({done, err, nr} !== {1'b1, 1'b1, 32'd0}) begin
        fails++; $display("FAIL misaligned addr=%h done=%0d err=%0d reads=%0d want 1/1/0", a, done, err, nr);
      end
      @(negedge clk);
      v = snap(0);
      checks++;
      if (v.err !== 1'b0 || v.valid !== 1'b0) begin
        fails++; $display("FAIL misaligned_pulse addr=%h err=%b valid=%b after pulse want 0/0", a, v.err, v.valid);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d, instr, wd; logic [7:0] wa, ga; logic err;
    int lat, nr, na, nw, nh, j; bit done;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 9) < 4) begin
        a = $urandom; a[1:0] = 2'b00; d = $urandom;
        do_load(0, a, d, na, nw, nr, nh, wa, wd, done);
        checks++;
        if ({done, na, nw, wa, wd} !== {1'b1, 32'd1, 32'd1, a[7:0], d}) begin
          fails++; $display("FAIL rand_load addr=%h done=%0d acks=%0d we=%0d maddr=%h data=%h want 1/1/1/%h/%h",
                            a, done, na, nw, wa, wd, a[7:0], d);
        end
        ref1[a[7:2]] = d; wr1[a[7:2]] = 1'b1;
      end else begin
        do j = $urandom_range(0, 63); while (!wr1[j]);
        a = $urandom; a[7:0] = {j[5:0], 2'b00};
        do_fetch(0, a, instr, lat, err, nr, ga, done);
        checks++;
        if ({done, err, lat, ga, instr} !== {1'b1, 1'b0, 32'd2, a[7:0], ref1[j]}) begin
          fails++; $display("FAIL rand_fetch addr=%h done=%0d err=%0d lat=%0d maddr=%h instr=%h want 1/0/2/%h/%h",
                            a, done, err, lat, ga, instr, a[7:0], ref1[j]);
        end
      end
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  // Both requesters always pending: at most 4 fetch grants between loader writes
  task automatic test_starve();
    snap_t v; logic [31:0] fa, d, wd; logic [7:0] wa;
    int gi, n_w, nr, na, nw, nh; bit stop, done, exp_w;
    fa = {24'h0, 8'($urandom_range(0, 63) << 2)};
    d  = $urandom;
    do_load(0, fa, d, na, nw, nr, nh, wa, wd, done);
    ref1[fa[7:2]] = d; wr1[fa[7:2]] = 1'b1;
    d = $urandom;
    set_fetch(0, 1'b1, fa);
    set_load(0, 1'b1, fa, d);
    gi = 0; n_w = 0; stop = 1'b0;
    for (int t = 0; t < 120 && !stop; t++) begin
      @(negedge clk);
      v = snap(0);
      if (v.en) begin
        exp_w = (gi % 5 == 4);
        checks++;
        if (v.we !== exp_w) begin
          fails++; $display("FAIL starve_order grant=%0d got write=%b want write=%b", gi, v.we, exp_w);
        end
        gi++;
      end
      if (v.valid) begin
        checks++;
        if (v.instr !== ref1[fa[7:2]]) begin
          fails++; $display("FAIL starve_data got %h want %h", v.instr, ref1[fa[7:2]]);
        end
        if (n_w >= 3) stop = 1'b1;
      end
      if (v.ack) begin
        ref1[fa[7:2]] = d;
        n_w++;
      end
      tick();
      if (v.ack) begin
        if (n_w < 3) begin d = $urandom; set_load(0, 1'b1, fa, d); end
        else set_load(0, 1'b0, fa, d);
      end
    end
    set_fetch(0, 1'b0, fa);
    set_load(0, 1'b0, fa, d);
    checks++;
    if (!stop || n_w != 3 || gi != 16) begin
      fails++; $display("FAIL starve_run finished=%0d writes=%0d grants=%0d want 1/3/16", stop, n_w, gi);
    end
    tick();
  endtask

  task automatic test_latency_sweep();
    logic [31:0] a, d, instr, wd; logic [7:0] wa, ga; logic err;
    int lat, nr, na, nw, nh; bit done;
    for (int i = 0; i < 3; i++) begin
      a = $urandom; a[1:0] = 2'b00; d = $urandom;
      do_load(1, a, d, na, nw, nr, nh, wa, wd, done);
      checks++;
      if ({done, na, wa, wd} !== {1'b1, 32'd1, a[7:0], d}) begin
        fails++; $display("FAIL lat3_load done=%0d acks=%0d maddr=%h data=%h want 1/1/%h/%h",
                          done, na, wa, wd, a[7:0], d);
      end
      do_fetch(1, a, instr, lat, err, nr, ga, done);
      checks++;
      if ({done, err, lat, nr, instr} !== {1'b1, 1'b0, 32'd4, 32'd1, d}) begin
        fails++; $display("FAIL lat3_fetch addr=%h done=%0d err=%0d lat=%0d reads=%0d instr=%h want 1/0/4/1/%h",
                          a, done, err, lat, nr, instr, d);
      end
    end
  endtask

  task automatic test_reset_mid_read();
    snap_t v; logic [31:0] instr; logic [7:0] ga; logic err;
    int lat, nr; bit seen, done;
    seen = 1'b0;
    set_fetch(0, 1'b1, 32'd28);
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      v = snap(0);
      if (v.en) seen = 1'b1;
      tick();
    end
    rst_n = 1'b0;
    @(negedge clk);
    v = snap(0);
    checks++;
    if (!seen || v !== '0) begin
      fails++; $display("FAIL reset_mid_read granted=%0d outputs=%h want 1/0", seen, v);
    end
    tick();
    rst_n = 1'b1;
    do_fetch(0, 32'd28, instr, lat, err, nr, ga, done);
    checks++;
    if ({done, err, lat, nr, instr} !== {1'b1, 1'b0, 32'd2, 32'd1, ref1[7]}) begin
      fails++; $display("FAIL reset_refetch done=%0d err=%0d lat=%0d reads=%0d instr=%h want 1/0/2/1/%h",
                        done, err, lat, nr, instr, ref1[7]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 64; i++) begin ref1[i] = '0; wr1[i] = 1'b0; end
    set_boot(0, 1'b0); set_fetch(0, 1'b0, '0); set_load(0, 1'b0, '0, '0);
    set_boot(1, 1'b0); set_fetch(1, 1'b0, '0); set_load(1, 1'b0, '0, '0);
    tick();
    test_reset();
    test_basic_fetch();
    test_boot_load();
    test_misaligned();
    test_random();
    test_starve();
    test_latency_sweep();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
